stepdown_seq_ctrl: RTL and testbench
====================================

STEPDOWN_SEQ_CTRL -- requirements
Module: stepdown_seq_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter DT_CYCLES, default 4: dead-time length in clocks, legal 1..15.
REQ-002 SHALL have parameter SS_DIV, default 16: clocks per soft-start DAC step, legal 1..255.
REQ-003 SHALL have parameter HICCUP_CYCLES, default 1024: fault hold-off in clocks, legal 1..65535.

Ports:
REQ-004 SHALL have port CLK  in  1  single clock; everything sequential runs on its rising edge.
REQ-005 SHALL have port RST  in  1  asynchronous reset, active-high.
REQ-006 SHALL have ports CELV, CELG, SUB  in  1 each  supply/substrate pins, with no logic function.
REQ-007 SHALL have port en  in  1  converter enable.
REQ-008 SHALL have port uvlo  in  1  supply undervoltage, high means unsafe.
REQ-009 SHALL have port ocp  in  1  overcurrent comparator, high means fault.
REQ-010 SHALL have port pwm_in  in  1  loop PWM demand, high means high-side requested.
REQ-011 SHALL have port hs_on  out  1  high-side gate enable.
REQ-012 SHALL have port ls_on  out  1  low-side gate enable.
REQ-013 SHALL have port ss_ref  out  8  soft-start reference code to the loop DAC.
REQ-014 SHALL have port pgood  out  1  soft-start complete, converter in regulation mode.
REQ-015 SHALL have port fault  out  1  high while in hiccup.
REQ-016 SHALL have port fault_cnt  out  8  count of OCP trips, saturating.

Function
REQ-017 All inputs SHALL be treated as synchronous, and all outputs SHALL be registered.
REQ-018 The master FSM SHALL have states IDLE, SS, RUN, FAULT, and SHALL enter IDLE on reset.
REQ-019 From any state, (!en | uvlo) sampled SHALL take the FSM to IDLE on the next edge; this SHALL have the highest priority.
REQ-020 IDLE->SS SHALL occur when en & !uvlo; ss_ref SHALL be 0 in IDLE.
REQ-021 In SS, a prescaler SHALL count SS_DIV clocks, after which ss_ref SHALL increment by 1.
REQ-022 In SS, when ss_ref is 255 the FSM SHALL go to RUN on the same step edge, and ss_ref SHALL never wrap.
REQ-023 ss_ref SHALL hold 255 in RUN, and pgood SHALL be 1 in RUN only.
REQ-024 In SS or RUN, ocp sampled SHALL take the FSM to FAULT; ss_ref SHALL clear to 0 and fault_cnt SHALL increment, saturating at 255.
REQ-025 In FAULT, fault SHALL be 1, and a counter SHALL run for HICCUP_CYCLES clocks, then the FSM SHALL go to SS.
REQ-026 ocp SHALL be ignored during FAULT.
REQ-027 The driver FSM SHALL have states OFF, LS, DT_LH, HS, DT_HL, with hs_on=1 only in HS and ls_on=1 only in LS.
REQ-028 hs_on and ls_on SHALL never be 1 simultaneously.
REQ-029 In master states IDLE and FAULT, the driver SHALL be forced to OFF on the next edge.
REQ-030 In master states SS and RUN: OFF SHALL go to DT_LH if pwm_in, else to LS.
REQ-031 LS->DT_LH SHALL occur on pwm_in=1, loading the dead-time counter with DT_CYCLES-1.
REQ-032 DT_LH SHALL decrement the counter; at 0 it SHALL go to HS if pwm_in, else abort directly to LS.
REQ-033 HS->DT_HL SHALL occur on pwm_in=0, loading DT_CYCLES-1.
REQ-034 DT_HL at 0 SHALL go to LS if !pwm_in, else to DT_LH with DT_CYCLES-1 reloaded.
REQ-035 Timing SHALL be: pwm_in sampled high at edge k while in LS -> ls_on=0 after edge k, hs_on=1 after edge k+DT_CYCLES.
REQ-036 OCP SHALL have precedence over normal driver transitions: when ocp is sampled high in HS, hs_on SHALL be 0 after the next edge.

Reset
REQ-037 RST high SHALL asynchronously force: master=IDLE, driver=OFF, hs_on=0, ls_on=0, ss_ref=0, pgood=0, fault=0, fault_cnt=0, and all counters 0.
REQ-038 Reset asserted mid-SS, mid-dead-time or mid-HS SHALL take effect immediately without waiting for a clock.
REQ-039 After deassertion, the first transition SHALL be evaluated at the next rising edge.
REQ-040 fault_cnt SHALL be cleared only by RST.

Verification
REQ-041 Soft-start: en=1, uvlo=0, SS_DIV=16 -> ss_ref steps 0..255 every 16 clocks, and pgood=1 at clock 256*16 +/-1 after en sampled.
REQ-042 Dead-time: RUN with pwm_in toggling 50% at period 40 and DT_CYCLES=4 -> every hs_on rise lags the ls_on fall by exactly 4 clocks (and vice versa), with no overlap on any cycle.
REQ-043 Short pulse: pwm_in high for 2 clocks from LS with DT_CYCLES=4 -> hs_on stays 0, and ls_on returns to 1 after dead-time expiry.
REQ-044 OCP hiccup: ocp pulsed during HS -> hs_on=0 after the next edge, fault=1 for 1024 clocks, fault_cnt=1, then SS restarts from ss_ref=0; 300 OCP trips -> fault_cnt=255.
REQ-045 Priority: ocp and uvlo asserted in the same cycle -> IDLE, fault stays 0, fault_cnt is unchanged.
REQ-046 Async reset: RST pulsed between clock edges during DT_LH -> all outputs are 0 immediately, and a restart from IDLE behaves as in REQ-041.

Source files
------------

// File: rtl/stepdown_seq_ctrl_if.sv
// Control and status bundle of the step-down sequencer.
// There is no valid/ready pair. The controller samples every input on each
// rising clock edge. Every output changes only on a rising edge or on reset.
// mst_state and drv_state give a read-only view of the two FSMs.
interface stepdown_seq_ctrl_if;
    logic       en;
    logic       uvlo;
    logic       ocp;
    logic       pwm_in;
    logic       hs_on;
    logic       ls_on;
    logic [7:0] ss_ref;
    logic       pgood;
    logic       fault;
    logic [7:0] fault_cnt;
    logic [1:0] mst_state;
    logic [2:0] drv_state;

    modport master (
        output en, uvlo, ocp, pwm_in,
        input  hs_on, ls_on, ss_ref, pgood, fault, fault_cnt, mst_state, drv_state
    );

    modport slave (
        input  en, uvlo, ocp, pwm_in,
        output hs_on, ls_on, ss_ref, pgood, fault, fault_cnt, mst_state, drv_state
    );
endinterface

// File: rtl/stepdown_seq_ctrl.sv
// Step-down converter sequencer. It has a master FSM (idle / soft-start /
// run / hiccup) and a gate-driver FSM that puts dead time between the
// high-side and low-side gate enables. Every output comes from a flop.
module stepdown_seq_ctrl #(
    parameter int DT_CYCLES     = 4,
    parameter int SS_DIV        = 16,
    parameter int HICCUP_CYCLES = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CELV,
    input  logic               CELG,
    input  logic               SUB,
    stepdown_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_SS    = 2'd1,
        M_RUN   = 2'd2,
        M_FAULT = 2'd3
    } mst_e;

    typedef enum logic [2:0] {
        D_OFF   = 3'd0,
        D_LS    = 3'd1,
        D_DT_LH = 3'd2,
        D_HS    = 3'd3,
        D_DT_HL = 3'd4
    } drv_e;

    localparam logic [3:0]  DT_LOAD  = 4'(DT_CYCLES - 1);
    localparam logic [7:0]  SS_LAST  = 8'(SS_DIV - 1);
    localparam logic [15:0] HIC_LAST = 16'(HICCUP_CYCLES - 1);

    mst_e        mst_q, mst_d;
    drv_e        drv_q, drv_d;
    logic [7:0]  ps_q, ps_d;
    logic [7:0]  ss_ref_q, ss_ref_d;
    logic [15:0] hic_q, hic_d;
    logic [3:0]  dt_q, dt_d;
    logic [7:0]  fault_cnt_q, fault_cnt_d;
    logic        hs_on_q, hs_on_d;
    logic        ls_on_q, ls_on_d;
    logic        pgood_q, pgood_d;
    logic        fault_q, fault_d;

    logic kill;
    logic ss_step;
    logic drv_force;
    logic unused_supply;

    // The supply and substrate pins have no logic function.
    assign unused_supply = ^{CELV, CELG, SUB};

    // Disable or undervoltage overrides everything else, including an OCP trip.
    assign kill    = !bus.en || bus.uvlo;
    assign ss_step = (ps_q == SS_LAST);

    // The driver stays OFF while the master is inactive in the current or next
    // cycle. So an OCP trip or a disable drops the gates on the edge that samples it.
    assign drv_force = (mst_q == M_IDLE) || (mst_q == M_FAULT) ||
                       (mst_d == M_IDLE) || (mst_d == M_FAULT);

    // State register: all flops, asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mst_q       <= M_IDLE;
            drv_q       <= D_OFF;
            ps_q        <= '0;
            ss_ref_q    <= '0;
            hic_q       <= '0;
            dt_q        <= '0;
            fault_cnt_q <= '0;
            hs_on_q     <= 1'b0;
            ls_on_q     <= 1'b0;
            pgood_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            mst_q       <= mst_d;
            drv_q       <= drv_d;
            ps_q        <= ps_d;
            ss_ref_q    <= ss_ref_d;
            hic_q       <= hic_d;
            dt_q        <= dt_d;
            fault_cnt_q <= fault_cnt_d;
            hs_on_q     <= hs_on_d;
            ls_on_q     <= ls_on_d;
            pgood_q     <= pgood_d;
            fault_q     <= fault_d;
        end
    end

    // Master next state: soft-start ramp, OCP trip, hiccup hold-off.
    always_comb begin
        mst_d       = mst_q;
        ps_d        = ps_q;
        ss_ref_d    = ss_ref_q;
        hic_d       = hic_q;
        fault_cnt_d = fault_cnt_q;
        if (kill) begin
            mst_d    = M_IDLE;
            ps_d     = '0;
            ss_ref_d = '0;
            hic_d    = '0;
        end else begin
            case (mst_q)
                M_IDLE: begin
                    mst_d    = M_SS;
                    ps_d     = '0;
                    ss_ref_d = '0;
                end
                M_SS, M_RUN: begin
                    if (bus.ocp) begin
                        mst_d    = M_FAULT;
                        ps_d     = '0;
                        ss_ref_d = '0;
                        hic_d    = '0;
                        if (fault_cnt_q != 8'hFF) begin
                            fault_cnt_d = fault_cnt_q + 8'd1;
                        end
                    end else if (mst_q == M_SS) begin
                        if (ss_step) begin
                            ps_d = '0;
                            // At full scale the step edge hands over to RUN instead of wrapping.
                            if (ss_ref_q == 8'hFF) begin
                                mst_d = M_RUN;
                            end else begin
                                ss_ref_d = ss_ref_q + 8'd1;
                            end
                        end else begin
                            ps_d = ps_q + 8'd1;
                        end
                    end
                end
                M_FAULT: begin
                    if (hic_q == HIC_LAST) begin
                        mst_d = M_SS;
                        hic_d = '0;
                        ps_d  = '0;
                    end else begin
                        hic_d = hic_q + 16'd1;
                    end
                end
                default: mst_d = M_IDLE;
            endcase
        end
    end

    // Driver next state: dead time is inserted on every change of gate side.
    always_comb begin
        drv_d = drv_q;
        dt_d  = dt_q;
        if (drv_force) begin
            drv_d = D_OFF;
            dt_d  = '0;
        end else begin
            case (drv_q)
                D_OFF: begin
                    if (bus.pwm_in) begin
                        drv_d = D_DT_LH;
                        dt_d  = DT_LOAD;
                    end else begin
                        drv_d = D_LS;
                    end
                end
                D_LS: begin
                    if (bus.pwm_in) begin
                        drv_d = D_DT_LH;
                        dt_d  = DT_LOAD;
                    end
                end
                D_DT_LH: begin
                    if (dt_q == 4'd0) begin
                        drv_d = bus.pwm_in ? D_HS : D_LS;
                    end else begin
                        dt_d = dt_q - 4'd1;
                    end
                end
                D_HS: begin
                    if (!bus.pwm_in) begin
                        drv_d = D_DT_HL;
                        dt_d  = DT_LOAD;
                    end
                end
                D_DT_HL: begin
                    if (dt_q == 4'd0) begin
                        if (bus.pwm_in) begin
                            drv_d = D_DT_LH;
                            dt_d  = DT_LOAD;
                        end else begin
                            drv_d = D_LS;
                        end
                    end else begin
                        dt_d = dt_q - 4'd1;
                    end
                end
                default: drv_d = D_OFF;
            endcase
        end
    end

    // Output decode: outputs follow the next states and are registered, so no decode glitches reach the pins.
    always_comb begin
        hs_on_d = (drv_d == D_HS);
        ls_on_d = (drv_d == D_LS);
        pgood_d = (mst_d == M_RUN);
        fault_d = (mst_d == M_FAULT);
    end

    assign bus.hs_on     = hs_on_q;
    assign bus.ls_on     = ls_on_q;
    assign bus.ss_ref    = ss_ref_q;
    assign bus.pgood     = pgood_q;
    assign bus.fault     = fault_q;
    assign bus.fault_cnt = fault_cnt_q;
    assign bus.mst_state = mst_q;
    assign bus.drv_state = drv_q;
endmodule

// File: tb/tb_stepdown_seq_ctrl.sv
// Bench for stepdown_seq_ctrl. Directed scenarios are followed by random
// traffic. Every cycle the outputs are compared with a reference model.
module tb_stepdown_seq_ctrl;
    localparam int DT  = 4;
    localparam int SSD = 4;
    localparam int HIC = 64;

    localparam int ST_IDLE = 0;
    localparam int ST_SS   = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_FLT  = 3;
    localparam int G_OFF   = 0;
    localparam int G_LS    = 1;
    localparam int G_HS    = 2;
    localparam int G_DEAD  = 3;

    logic CLK  = 1'b0;
    logic RST  = 1'b0;
    logic CELV = 1'b1;
    logic CELG = 1'b0;
    logic SUB  = 1'b0;

    stepdown_seq_ctrl_if bus();

    stepdown_seq_ctrl #(
        .DT_CYCLES(DT),
        .SS_DIV(SSD),
        .HICCUP_CYCLES(HIC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CELV(CELV),
        .CELG(CELG),
        .SUB(SUB),
        .bus(bus)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish (mst=%0d drv=%0d), required finish", bus.mst_state, bus.drv_state);
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] exp_q[$];

    // Reference model: spec-level quantities, not the RTL encoding
    int m_st, m_sst, m_ref, m_hic, m_cnt;
    int g, dt_left, dt_up;

    // Edge tracking for the dead-time measurements
    int cyc = 0;
    int t_ls_fall = 0, t_hs_fall = 0;
    int n_hs_rise = 0, n_ls_rise = 0;
    logic prev_hs = 1'b0, prev_ls = 1'b0;
    logic lag_en = 1'b0, hs_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; m_sst = 0; m_ref = 0; m_hic = 0; m_cnt = 0;
        g = G_OFF; dt_left = 0; dt_up = 0;
        exp_q.delete();
    endtask

    task automatic start_dead(input int up);
        g = G_DEAD;
        dt_left = DT;
        dt_up = up;
    endtask

    // One rising edge of the specified behaviour, applied to the sampled inputs
    task automatic model_step();
        int nxt;
        bit forced;
        nxt = m_st;
        if (!bus.en || bus.uvlo) begin
            nxt = ST_IDLE; m_ref = 0;
        end else if (m_st == ST_IDLE) begin
            nxt = ST_SS; m_sst = 0; m_ref = 0;
        end else if ((m_st == ST_SS || m_st == ST_RUN) && bus.ocp) begin
            nxt = ST_FLT; m_ref = 0; m_hic = 0;
            if (m_cnt < 255) m_cnt++;
        end else if (m_st == ST_SS) begin
            m_sst++;
            if (m_sst >= 256 * SSD) begin
                nxt = ST_RUN; m_ref = 255;
            end else begin
                m_ref = m_sst / SSD;
            end
        end else if (m_st == ST_FLT) begin
            m_hic++;
            if (m_hic == HIC) begin
                nxt = ST_SS; m_sst = 0;
            end
        end
        forced = (m_st == ST_IDLE) || (m_st == ST_FLT) || (nxt == ST_IDLE) || (nxt == ST_FLT);
        m_st = nxt;
        if (forced) begin
            g = G_OFF;
        end else begin
            case (g)
                G_OFF:  if (bus.pwm_in) start_dead(1); else g = G_LS;
                G_LS:   if (bus.pwm_in) start_dead(1);
                G_HS:   if (!bus.pwm_in) start_dead(0);
                default: begin
                    dt_left--;
                    if (dt_left == 0) begin
                        if (!bus.pwm_in) g = G_LS;
                        else if (dt_up == 1) g = G_HS;
                        else start_dead(1);
                    end
                end
            endcase
        end
        exp_q.push_back({g == G_HS, g == G_LS, m_st == ST_RUN, m_st == ST_FLT, 8'(m_ref), 8'(m_cnt)});
    endtask

    task automatic compare_outputs();
        logic [19:0] e;
        e = exp_q.pop_front();
        check("hs_on", bus.hs_on, e[19]);
        check("ls_on", bus.ls_on, e[18]);
        check("pgood", bus.pgood, e[17]);
        check("fault", bus.fault, e[16]);
        check("ss_ref", bus.ss_ref, e[15:8]);
        check("fault_cnt", bus.fault_cnt, e[7:0]);
        check("gate_overlap", bus.hs_on & bus.ls_on, 0);
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cyc++;
        compare_outputs();
        if (bus.hs_on) hs_seen = 1'b1;
        if (prev_ls && !bus.ls_on) t_ls_fall = cyc;
        if (prev_hs && !bus.hs_on) t_hs_fall = cyc;
        if (lag_en && !prev_hs && bus.hs_on) begin
            n_hs_rise++;
            check("lag_ls_fall_to_hs_rise", cyc - t_ls_fall, DT);
        end
        if (lag_en && !prev_ls && bus.ls_on) begin
            n_ls_rise++;
            check("lag_hs_fall_to_ls_rise", cyc - t_hs_fall, DT);
        end
        prev_hs = bus.hs_on;
        prev_ls = bus.ls_on;
    endtask

    task automatic run_softstart(input string tag);
        int n;
        n = 0;
        bus.en = 1'b1; bus.uvlo = 1'b0; bus.ocp = 1'b0;
        do begin
            tick();
            n++;
        end while (!bus.pgood && n < 256 * SSD + 16);
        check(tag, n - 1, 256 * SSD);
        check("softstart_ref_full", bus.ss_ref, 255);
    endtask

    task automatic wait_fault_clear();
        int guard;
        guard = 0;
        while (bus.fault && guard < HIC + 8) begin
            tick();
            guard++;
        end
        check("fault_clears", bus.fault, 0);
    endtask

    // Stimulus and final report
    initial begin
        int n;
        bus.en = 1'b0; bus.uvlo = 1'b0; bus.ocp = 1'b0; bus.pwm_in = 1'b0;
        model_reset();

        // Reset state
        #2 RST = 1'b1;
        @(negedge CLK);
        check("rst_hs_on", bus.hs_on, 0);
        check("rst_ls_on", bus.ls_on, 0);
        check("rst_ss_ref", bus.ss_ref, 0);
        check("rst_pgood", bus.pgood, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_fault_cnt", bus.fault_cnt, 0);
        RST = 1'b0;
        model_reset();

        // Soft-start ramp to pgood
        run_softstart("softstart_pgood_time");

        // Dead time with a 50% pwm of period 40
        lag_en = 1'b1;
        for (int p = 0; p < 8; p++) begin
            bus.pwm_in = (p % 2 == 0);
            repeat (20) tick();
        end
        lag_en = 1'b0;
        check("dt_hs_rises", n_hs_rise, 4);
        check("dt_ls_rises", n_ls_rise, 4);

        // Short pulse from LS: the dead time expires back into LS
        hs_seen = 1'b0;
        bus.pwm_in = 1'b1;
        repeat (2) tick();
        bus.pwm_in = 1'b0;
        repeat (8) tick();
        check("short_no_hs", hs_seen, 0);
        check("short_ls_back", bus.ls_on, 1);

        // OCP during HS, then hiccup
        bus.pwm_in = 1'b1;
        n = 0;
        while (!bus.hs_on && n < 20) begin tick(); n++; end
        check("reach_hs", bus.hs_on, 1);
        bus.ocp = 1'b1;
        tick();
        bus.ocp = 1'b0;
        check("ocp_hs_off", bus.hs_on, 0);
        check("ocp_fault_set", bus.fault, 1);
        check("ocp_cnt_one", bus.fault_cnt, 1);
        n = 1;
        while (bus.fault && n < HIC + 8) begin
            tick();
            if (bus.fault) n++;
        end
        check("hiccup_length", n, HIC);
        check("restart_ref_zero", bus.ss_ref, 0);
        repeat (SSD) tick();
        check("restart_first_step", bus.ss_ref, 1);

        // OCP and UVLO together: UVLO wins, no trip counted
        bus.ocp = 1'b1; bus.uvlo = 1'b1;
        tick();
        check("prio_fault", bus.fault, 0);
        check("prio_cnt", bus.fault_cnt, 1);
        check("prio_ref", bus.ss_ref, 0);
        bus.ocp = 1'b0; bus.uvlo = 1'b0;
        repeat (2) tick();

        // 300 trips in total saturate the counter
        for (int i = 0; i < 299; i++) begin
            bus.ocp = 1'b1;
            tick();
            bus.ocp = 1'b0;
            wait_fault_clear();
        end
        check("cnt_saturated", bus.fault_cnt, 255);

        // Asynchronous reset between edges during DT_LH
        bus.pwm_in = 1'b0;
        repeat (20) tick();
        bus.pwm_in = 1'b1;
        repeat (2) tick();
        check("pre_rst_in_dead", bus.hs_on | bus.ls_on, 0);
        #1 RST = 1'b1;
        #1;
        check("arst_hs_on", bus.hs_on, 0);
        check("arst_ls_on", bus.ls_on, 0);
        check("arst_ss_ref", bus.ss_ref, 0);
        check("arst_pgood", bus.pgood, 0);
        check("arst_fault", bus.fault, 0);
        check("arst_fault_cnt", bus.fault_cnt, 0);
        #1 RST = 1'b0;
        model_reset();
        prev_hs = 1'b0; prev_ls = 1'b0;
        run_softstart("restart_pgood_time");

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.en   = ($urandom_range(0, 999) != 0);
            bus.uvlo = ($urandom_range(0, 1499) == 0);
            bus.ocp  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0) bus.pwm_in = ~bus.pwm_in;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
